// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one synchronous-read word memory between two
// picorv32-style native-interface masters, one transaction in flight at a time.
module mem_arbiter #(
  parameter int WORDS     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_valid,
  input  logic [31:0]          m0_addr,
  input  logic [31:0]          m0_wdata,
  input  logic [3:0]           m0_wstrb,
  output logic                 m0_ready,
  output logic [31:0]          m0_rdata,
  input  logic                 m1_valid,
  input  logic [31:0]          m1_addr,
  input  logic [31:0]          m1_wdata,
  input  logic [3:0]           m1_wstrb,
  output logic                 m1_ready,
  output logic [31:0]          m1_rdata,
  output logic [3:0]           mem_wen,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic                 oob_err,
  output logic [1:0]           dbg_state
);

  // Handshake: a master raises valid and holds addr/wdata/wstrb stable until it
  // sees ready=1 for exactly one cycle; ready never depends on valid combinationally.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 oob_q, oob_d;
  logic [3:0]           mem_wen_q, mem_wen_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;

  logic                 win;
  logic [31:0]          win_addr;
  logic [31:0]          win_wdata;
  logic [3:0]           win_wstrb;
  logic                 win_oob;
  logic                 unused_addr_bits;

  // Word addressing drops the byte offset.
  assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0], WORDS[0]};

  always_comb begin
    // On a tie the port that did not win last time is chosen.
    if (m0_valid && m1_valid) win = ~last_q;
    else                      win = m1_valid;
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
    win_wstrb = win ? m1_wstrb : m0_wstrb;
    win_oob   = (win_addr[31:ADDR_BITS+2] != '0);
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    oob_d       = oob_q;
    mem_wen_d   = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d     = ACCESS;
          owner_d     = win;
          last_d      = win;
          oob_d       = win_oob;
          mem_addr_d  = win_addr[ADDR_BITS+1:2];
          mem_wdata_d = win_wdata;
          mem_wen_d   = win_oob ? 4'b0000 : win_wstrb;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      oob_q       <= 1'b0;
      mem_wen_q   <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      oob_q       <= oob_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  logic        resp;
  logic [31:0] resp_data;

  always_comb begin
    resp      = (state_q == RESP);
    resp_data = oob_q ? 32'd0 : mem_rdata;
    m0_ready  = resp && !owner_q;
    m1_ready  = resp && owner_q;
    m0_rdata  = m0_ready ? resp_data : 32'd0;
    m1_rdata  = m1_ready ? resp_data : 32'd0;
    oob_err   = resp && oob_q;
  end

  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read memory.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  mem_wen;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        oob_err;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  logic [31:0] mem [0:31];

  mem_arbiter #(.WORDS(32), .ADDR_BITS(5)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .oob_err(oob_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: byte-enabled write, one-cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wen[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
  endtask

  task automatic drive_m1(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_m0_ready"}, 32'(m0_ready), 32'd0);
    check({tag, "_m1_ready"}, 32'(m1_ready), 32'd0);
    check({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    check({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    check({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_oob_err"}, 32'(oob_err), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[0] = 32'hCAFEF00D;
    mem[3] = 32'hDEADBEEF;
    mem[4] = 32'h11223344;
    mem[5] = 32'hA5A5A5A5;
    mem[6] = 32'h5A5A5A5A;
    reset = 1'b1;
    drive_m0(1'b0, 32'd0, 32'd0, 4'd0);
    drive_m1(1'b0, 32'd0, 32'd0, 4'd0);
    step(); step();
    check_idle_outputs("reset");
    reset = 1'b0;

    // Single read on port 0
    drive_m0(1'b1, 32'h0C, 32'd0, 4'd0);
    step();
    check("rd0_state", 32'(dbg_state), 32'd1);
    check("rd0_mem_addr", 32'(mem_addr), 32'd3);
    check("rd0_early_ready", 32'(m0_ready), 32'd0);
    step();
    check("rd0_ready", 32'(m0_ready), 32'd1);
    check("rd0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd0_m1_ready", 32'(m1_ready), 32'd0);
    check("rd0_oob", 32'(oob_err), 32'd0);
    drive_m0(1'b0, 32'd0, 32'd0, 4'd0);
    step();
    check("rd0_back_idle", 32'(dbg_state), 32'd0);
    check("rd0_ready_clr", 32'(m0_ready), 32'd0);

    // Byte write on port 1 then read back
    drive_m1(1'b1, 32'h10, 32'h0000AB00, 4'b0010);
    check("wr1_wen_pre", 32'(mem_wen), 32'd0);
    step();
    check("wr1_wen", 32'(mem_wen), 32'h2);
    check("wr1_mem_addr", 32'(mem_addr), 32'd4);
    check("wr1_mem_wdata", mem_wdata, 32'h0000AB00);
    step();
    check("wr1_wen_clr", 32'(mem_wen), 32'd0);
    check("wr1_ready", 32'(m1_ready), 32'd1);
    check("wr1_m0_ready", 32'(m0_ready), 32'd0);
    drive_m1(1'b1, 32'h10, 32'd0, 4'd0);
    step();
    check("wr1_wen_idle", 32'(mem_wen), 32'd0);
    step(); step();
    check("rb1_ready", 32'(m1_ready), 32'd1);
    check("rb1_rdata", m1_rdata, 32'h1122AB44);
    drive_m1(1'b0, 32'd0, 32'd0, 4'd0);
    step();

    // Out-of-range read, then write, then read word 0 to show it is untouched
    drive_m0(1'b1, 32'h80, 32'd0, 4'd0);
    step();
    check("oob_rd_wen", 32'(mem_wen), 32'd0);
    check("oob_rd_err_early", 32'(oob_err), 32'd0);
    step();
    check("oob_rd_ready", 32'(m0_ready), 32'd1);
    check("oob_rd_rdata", m0_rdata, 32'd0);
    check("oob_rd_err", 32'(oob_err), 32'd1);
    drive_m0(1'b1, 32'h80, 32'hFFFFFFFF, 4'hF);
    step();
    check("oob_gap_err", 32'(oob_err), 32'd0);
    step();
    check("oob_wr_wen", 32'(mem_wen), 32'd0);
    step();
    check("oob_wr_ready", 32'(m0_ready), 32'd1);
    check("oob_wr_err", 32'(oob_err), 32'd1);
    drive_m0(1'b1, 32'h00, 32'd0, 4'd0);
    step(); step(); step();
    check("oob_chk_ready", 32'(m0_ready), 32'd1);
    check("oob_chk_rdata", m0_rdata, 32'hCAFEF00D);
    check("oob_chk_err", 32'(oob_err), 32'd0);
    drive_m0(1'b0, 32'd0, 32'd0, 4'd0);
    step();

    // Reset during the ACCESS cycle of an m1 write
    drive_m1(1'b1, 32'h1C, 32'h12345678, 4'hF);
    step();
    check("rst_acc_wen", 32'(mem_wen), 32'hF);
    reset = 1'b1;
    drive_m1(1'b0, 32'd0, 32'd0, 4'd0);
    check("rst_acc_ready", 32'(m1_ready), 32'd0);
    step();
    check_idle_outputs("rst_mid");
    reset = 1'b0;
    drive_m0(1'b1, 32'h1C, 32'd0, 4'd0);
    step();
    check("rst_after_state", 32'(dbg_state), 32'd1);
    step();
    check("rst_after_ready", 32'(m0_ready), 32'd1);
    check("rst_after_rdata", m0_rdata, 32'h12345678);
    drive_m0(1'b0, 32'd0, 32'd0, 4'd0);
    step();

    // Valid dropped in the ACCESS cycle
    drive_m0(1'b1, 32'h0C, 32'd0, 4'd0);
    step();
    drive_m0(1'b0, 32'h0C, 32'd0, 4'd0);
    step();
    check("drop_ready", 32'(m0_ready), 32'd1);
    check("drop_rdata", m0_rdata, 32'hDEADBEEF);
    step();
    check("drop_idle", 32'(dbg_state), 32'd0);
    check("drop_ready_clr", 32'(m0_ready), 32'd0);

    // Continuous contention from reset: grants alternate 0,1,0,1
    reset = 1'b1;
    drive_m0(1'b1, 32'h14, 32'd0, 4'd0);
    drive_m1(1'b1, 32'h18, 32'd0, 4'd0);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      logic exp0, exp1;
      step();
      exp0 = (i % 6 == 2);
      exp1 = (i % 6 == 5);
      check($sformatf("cont_m0_ready_%0d", i), 32'(m0_ready), 32'(exp0));
      check($sformatf("cont_m1_ready_%0d", i), 32'(m1_ready), 32'(exp1));
      check($sformatf("cont_m0_rdata_%0d", i), m0_rdata, exp0 ? 32'hA5A5A5A5 : 32'd0);
      check($sformatf("cont_m1_rdata_%0d", i), m1_rdata, exp1 ? 32'h5A5A5A5A : 32'd0);
    end
    drive_m0(1'b0, 32'd0, 32'd0, 4'd0);
    drive_m1(1'b0, 32'd0, 32'd0, 4'd0);
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port, synchronous-read word memory (one-cycle read latency, byte write enables) between two masters using the picorv32 native memory handshake (valid/ready/addr/wdata/wstrb/rdata). Sits between the CPU (port 0) and a second master such as a program loader or debug port (port 1) and the memory. Arbitration is round-robin, one transaction in flight at a time.

## Interface
- WORDS, 32: memory depth in 32-bit words; power of two, at least 2.
- ADDR_BITS, 5: memory word-address width, equal to log2(WORDS).

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- m0_valid, m1_valid  in  1  request; the master holds it until it sees ready.
- m0_addr, m1_addr  in  32  byte address; bits [1:0] are ignored.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte strobes; 0 means a read.
- m0_ready, m1_ready  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  32  read data; valid only while the same port's ready is 1, otherwise 0.
- mem_wen  out  4  byte write enables to the memory, registered.
- mem_addr  out  ADDR_BITS  word address to the memory, registered.
- mem_wdata  out  32  write data to the memory, registered.
- mem_rdata  in  32  memory read data, valid the cycle after mem_addr is presented.
- oob_err  out  1  one-cycle pulse with ready when the address falls outside memory.

## Operation
- FSM states: IDLE, ACCESS, RESP. Registers: `owner` (1 bit), `last` (1 bit), `oob` (1 bit).
- IDLE → ACCESS when either valid is 1. Winner selection:
  - Only one port valid: that port wins.
  - Both valid: the port not equal to `last` wins.
  - On the transition: `owner` and `last` take the winner; mem_addr takes winner addr[ADDR_BITS+1:2]; mem_wdata takes winner wdata.
  - mem_wen takes winner wstrb when the address is in range, else 0.
  - `oob` is set when winner addr[31:ADDR_BITS+2] is nonzero.
- ACCESS → RESP unconditionally. The memory samples mem_addr/mem_wen/mem_wdata at the end of ACCESS. mem_wen clears to 0 on leaving ACCESS.
- RESP → IDLE unconditionally. During RESP:
  - ready for `owner` is 1.
  - rdata for `owner` is mem_rdata, or 0 when `oob` is set.
  - oob_err equals `oob`.
- Write transactions also return ready. rdata during a write response equals mem_rdata and is don't-care for the master.
- mem_addr and mem_wdata hold their value outside the IDLE→ACCESS load.
- Protocol violation: if the owner drops valid before ready, the transaction still completes and ready is still pulsed.
- The non-owner's valid is not observed outside IDLE, and its ready stays 0.
- Reset values: state IDLE, `last`=1 (so port 0 wins the first tie), `owner`=0, `oob`=0. mem_wen=0, mem_addr=0, mem_wdata=0. All ready outputs 0, all rdata outputs 0, oob_err=0.
- Reset asserted during ACCESS: the registered mem_wen is still visible in that cycle, so the write completes at the memory; no ready is returned. Reset asserted during RESP: ready is still 1 in that cycle (it is combinational from state); next cycle is IDLE.

## Timing
- Request sampled in IDLE at cycle T: ACCESS in T+1, ready at T+2, earliest next grant decision at T+3.
- Minimum transaction latency is 2 cycles from the sampled valid to ready; throughput is 1 transaction per 3 cycles.
- A master that keeps valid high straight after ready (with new address/data) is re-arbitrated in the IDLE cycle following RESP.
- Under continuous contention the grants alternate 0,1,0,1 …; neither master waits more than 6 cycles from its valid to its grant.
- ready, rdata and oob_err are combinational from registered state and mem_rdata only; there is no combinational path from valid to ready.

## Test plan
- Single read, port 0: memory word 3 = 32'hDEADBEEF; m0 reads addr 32'h0C at cycle 0. Required: mem_addr=3 at cycle 1, m0_ready=1 and m0_rdata=32'hDEADBEEF at cycle 2, m1_ready stays 0.
- Byte write, port 1: m1 writes addr 32'h10, wstrb 4'b0010, wdata 32'h0000AB00 over word 32'h11223344. Required: mem_wen=4'b0010 for exactly one cycle; a later read returns 32'h1122AB44.
- Contention: both ports issue reads continuously from reset. Required: grant order 0,1,0,1 with ready pulses 3 cycles apart; each port gets its own data.
- Out of range: m0 reads addr 32'h80 with WORDS=32. Required: mem_wen=0, and at cycle 2 m0_ready=1, m0_rdata=0, oob_err=1. A write to the same address leaves memory unchanged.
- Reset mid-transaction: reset asserted in the ACCESS cycle of an m1 write. Required: the memory is written; m1_ready never pulses; all outputs are at reset values the next cycle; a new m0 request is then granted normally.
- Valid dropped early: m0 deasserts valid in the ACCESS cycle. Required: m0_ready still pulses at cycle 2 and the FSM returns to IDLE.
